// File: rtl/ones_pattern_gen.sv
// Sequential generator of the canonical WIDTH-bit vector holding exactly `count` ones,
// packed from index 0 upward and resolved CHUNK bits per cycle.
module ones_pattern_gen #(
  parameter int WIDTH = 127,
  parameter int CW    = 7,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [CW-1:0]    count,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [0:WIDTH-1] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = $clog2(NCHUNK * CHUNK + 1);
  // Shared width for pointer, latched count and bit-index compares.
  localparam int LW     = (PW > CW + 1) ? PW : CW + 1;

  localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);
  localparam logic [LW-1:0] CHUNK_L = LW'(CHUNK);
  localparam logic [LW-1:0] LAST_P  = LW'((NCHUNK - 1) * CHUNK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [LW-1:0]      p_r, p_s;
  logic [LW-1:0]      n_r, n_s;
  logic [0:WIDTH-1]   w_r, w_s;
  logic [0:WIDTH-1]   a_r, a_s;
  logic               sat_r, sat_s;
  logic               in_ready_r, in_ready_s;
  logic               out_valid_r, out_valid_s;
  logic [LW-1:0]      cnt_ext_s;

  // Next-state and datapath update for the accept / fill / handoff sequence.
  always_comb begin
    state_s     = state_r;
    p_s         = p_r;
    n_s         = n_r;
    w_s         = w_r;
    a_s         = a_r;
    sat_s       = sat_r;
    cnt_ext_s   = LW'(count);
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          n_s     = (cnt_ext_s > WIDTH_L) ? WIDTH_L : cnt_ext_s;
          sat_s   = sat_r | (cnt_ext_s > WIDTH_L);
          w_s     = {WIDTH{1'b0}};
          p_s     = {LW{1'b0}};
          state_s = FILL;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        // Only bits whose chunk base equals p are rewritten this cycle.
        for (int i = 0; i < WIDTH; i++) begin
          if (p_r == LW'((i / CHUNK) * CHUNK)) begin
            w_s[i] = (LW'(i) < n_r);
          end else begin
            w_s[i] = w_r[i];
          end
        end
        p_s = p_r + CHUNK_L;
        if (p_r == LAST_P) begin
          a_s     = w_s;
          state_s = DONE;
        end else begin
          state_s = FILL;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    in_ready_s  = (state_s == IDLE);
    out_valid_s = (state_s == DONE);
  end

  // State and output registers; asynchronous reset discards any pattern in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      p_r         <= {LW{1'b0}};
      n_r         <= {LW{1'b0}};
      w_r         <= {WIDTH{1'b0}};
      a_r         <= {WIDTH{1'b0}};
      sat_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      p_r         <= p_s;
      n_r         <= n_s;
      w_r         <= w_s;
      a_r         <= a_s;
      sat_r       <= sat_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign a         = a_r;
  assign sat       = sat_r;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed and randomized bench for ones_pattern_gen with a count scoreboard.
module tb_ones_pattern_gen;

  logic         clk;
  logic         rstn;
  logic [6:0]   count;
  logic         in_valid;
  logic         in_ready;
  logic [0:126] a;
  logic         out_valid;
  logic         out_ready;
  logic         sat;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  logic rand_rdy = 1'b0;
  int sb[$];

  ones_pattern_gen dut (
    .clk       (clk),
    .rstn      (rstn),
    .count     (count),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [0:126] pat(input int c);
    logic [0:126] v;
    for (int i = 0; i < 127; i++) v[i] = (i < c);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard: push on a pending accept, pop and compare on a pending output handshake.
  always @(negedge clk) begin
    int e;
    if (rstn && in_valid && in_ready) sb.push_back(int'(count));
    if (rstn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("pattern_n%0d", e), a, pat(e));
        chk($sformatf("popcount_n%0d", e), $countones(a), e);
      end
    end
  end

  task automatic send(input int c, output int t);
    int k;
    count = 7'(c);
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("accept_wait", in_ready, 1'b1);
    @(posedge clk);
    #1;
    t = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, lat, j, tmp;
    int ord[128];

    rstn = 1'b0; count = 7'd0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_a", a, 127'd0);
    chk("rst_sat", sat, 1'b0);

    // count=0 with latency measurement
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(0, t1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    chk("latency", lat, 16);
    chk("sat_after_0", sat, 1'b0);
    drain();

    // all ones
    send(127, t1);
    drain();

    // back-to-back 1 then 9
    send(1, t1);
    send(9, t2);
    chk("accept_spacing", t2 - t1, 18);
    drain();

    // long downstream stall
    out_ready = 1'b0;
    send(120, t1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("stall_reach_done", out_valid, 1'b1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("stall_a", a, pat(120));
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_out_valid", out_valid, 1'b1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_out_valid", out_valid, 1'b0);
    chk("release_in_ready", in_ready, 1'b1);
    chk("release_sb_empty", sb.size(), 0);

    // asynchronous reset during FILL cycle 7
    @(posedge clk); #1;
    send(64, t1);
    repeat (6) @(posedge clk);
    #1 rstn = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_a", a, 127'd0);
    chk("midrst_in_ready", in_ready, 1'b1);
    #4 rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_output", out_valid, 1'b0);
    @(posedge clk); #1;
    send(3, t1);
    drain();

    // randomized sweep of every count with random downstream stalls
    for (int i = 0; i < 128; i++) ord[i] = i;
    for (int i = 127; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
    end
    rand_rdy = 1'b1;
    for (int i = 0; i < 128; i++) send(ord[i], t1);
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("final_sat", sat, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(1, 0));
    end
  end

endmodule
